// File: rtl/rr_mux4to1.sv
// Four-channel round-robin stream multiplexer. Merges four valid/ready
// input channels into one registered output channel and tags each word with
// its source channel index so a downstream demux can route it back out.
module rr_mux4to1 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         in_valid,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         out_sel,
   input  logic               out_ready
);

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [1:0]       out_sel_q;
   logic [1:0]       last_grant_q;

   logic             load;
   logic             found;
   logic [1:0]       grant;
   logic [1:0]       idx;
   logic             accept;

   // Output register may take a new word when it is empty or draining now.
   assign load   = !out_valid_q || out_ready;
   assign accept = load && found && !rst;

   // Search channels starting just after the previous winner.
   always_comb begin
      found = 1'b0;
      grant = 2'd0;
      idx   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_grant_q + 2'(k);
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   // One-hot handshake toward the granted channel; held low during reset.
   always_comb begin
      in_ready = 4'b0000;
      if (accept) begin
         in_ready = 4'b0001 << grant;
      end
   end

   // Output register and arbitration pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sel_q    <= 2'd0;
         last_grant_q <= 2'd3;
      end else if (accept) begin
         out_valid_q  <= 1'b1;
         out_data_q   <= in_data[grant*WIDTH +: WIDTH];
         out_sel_q    <= grant;
         last_grant_q <= grant;
      end else if (load) begin
         out_valid_q  <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux4to1.sv
// Self-checking bench for the four-channel round-robin multiplexer.
module tb_rr_mux4to1;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: contents of the output register and the last winner.
   bit         m_valid;
   logic [7:0] m_data;
   int         m_sel;
   int         m_last;

   // Words accepted per source channel, awaiting arrival on the demux lane.
   logic [7:0] src_q [4][$];

   logic [31:0] pattern;

   rr_mux4to1 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // First requesting channel after `last`, searching in rotating order.
   function automatic int pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (v[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 4'b0000;
      in_data   = '0;
      out_ready = 1'b0;
      @(negedge clk);
      rst     = 1'b0;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_sel   = 0;
      m_last  = 3;
   endtask

   task automatic test_reset();
      do_reset();
      in_valid  = 4'b1111;
      in_data   = pattern;
      out_ready = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL reset_preload out_valid got %b want 1", out_valid);
      end
      // Assert reset mid-cycle; outputs must clear without a clock edge.
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_async got v=%b d=%h s=%0d want v=0 d=00 s=0",
                  out_valid, out_data, out_sel);
      end
      n_checks++;
      if (in_ready !== 4'b0000) begin
         n_fail++; $display("FAIL reset_in_ready got %b want 0000", in_ready);
      end
      #1 rst = 1'b0;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin
         n_fail++; $display("FAIL reset_first_grant got %b want 0001", in_ready);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      in_valid  = 4'b1111;
      in_data   = pattern;
      out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         #2;
         n_checks++;
         if (in_ready !== 4'(1 << (i % 4))) begin
            n_fail++;
            $display("FAIL rr_ready cycle %0d got %b want %b", i, in_ready, 4'(1 << (i % 4)));
         end
         if (i > 0) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== pattern[((i-1)%4)*8 +: 8]
                || out_sel !== 2'((i-1) % 4)) begin
               n_fail++;
               $display("FAIL rr_out cycle %0d got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                        i, out_valid, out_data, out_sel, pattern[((i-1)%4)*8 +: 8], (i-1) % 4);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_single();
      do_reset();
      in_valid  = 4'b0100;
      in_data   = 32'h005A_0000;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #2;
         n_checks++;
         if (in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready cycle %0d got %b want 0100", i, in_ready);
         end
         if (i > 0) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h5A || out_sel !== 2'd2) begin
               n_fail++;
               $display("FAIL single_out cycle %0d got v=%b d=%h s=%0d want v=1 d=5a s=2",
                        i, out_valid, out_data, out_sel);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid  = 4'b1111;
      in_data   = pattern;
      out_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_checks++;
         if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL bp_ready cycle %0d got %b want 0000", i, in_ready);
         end
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 8'hA0 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_hold cycle %0d got v=%b d=%h s=%0d want v=1 d=a0 s=0",
                     i, out_valid, out_data, out_sel);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #2;
      n_checks++;
      if (in_ready !== 4'b0010) begin
         n_fail++; $display("FAIL bp_release_ready got %b want 0010", in_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hB1 || out_sel !== 2'd1) begin
         n_fail++;
         $display("FAIL bp_release_out got v=%b d=%h s=%0d want v=1 d=b1 s=1",
                  out_valid, out_data, out_sel);
      end
   endtask

   task automatic test_idle_drain();
      do_reset();
      in_valid  = 4'b0010;
      in_data   = 32'h4433_2211;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 4'b0000;
      #2;
      n_checks++;
      if (in_ready !== 4'b0000) begin
         n_fail++; $display("FAIL idle_ready got %b want 0000", in_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h22 || out_sel !== 2'd1) begin
         n_fail++;
         $display("FAIL idle_drain got v=%b d=%h s=%0d want v=0 d=22 s=1",
                  out_valid, out_data, out_sel);
      end
      in_valid = 4'b1001;
      #2;
      n_checks++;
      if (in_ready !== 4'b1000) begin
         n_fail++; $display("FAIL idle_next_grant got %b want 1000", in_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h44 || out_sel !== 2'd3) begin
         n_fail++;
         $display("FAIL idle_next_out got v=%b d=%h s=%0d want v=1 d=44 s=3",
                  out_valid, out_data, out_sel);
      end
   endtask

   // Random traffic against the reference model, with the output fed to a
   // behavioural demux whose lanes must see each channel's words in order.
   task automatic test_random_loopback();
      int         g;
      bit         load;
      logic [3:0] exp_ready;
      logic [7:0] exp_word;
      int         lane;
      do_reset();
      for (int i = 0; i < 4; i++) src_q[i].delete();
      for (int c = 0; c < 400; c++) begin
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(3) != 0);
         #2;
         load      = !m_valid || out_ready;
         g         = load ? pick(in_valid, m_last) : -1;
         exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
         n_checks++;
         if (in_ready !== exp_ready) begin
            n_fail++; $display("FAIL rand_ready cycle %0d got %b want %b", c, in_ready, exp_ready);
         end
         n_checks++;
         if (out_valid !== m_valid || out_data !== m_data || out_sel !== 2'(m_sel)) begin
            n_fail++;
            $display("FAIL rand_out cycle %0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                     c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
         end
         // Demux lane enable: out_valid gated with the handshake.
         if (out_valid === 1'b1 && out_ready) begin
            lane = int'(out_sel);
            n_checks++;
            if (src_q[lane].size() == 0) begin
               n_fail++;
               $display("FAIL loop_lane%0d cycle %0d got %h want nothing pending",
                        lane, c, out_data);
            end else begin
               exp_word = src_q[lane].pop_front();
               if (out_data !== exp_word) begin
                  n_fail++;
                  $display("FAIL loop_lane%0d cycle %0d got %h want %h",
                           lane, c, out_data, exp_word);
               end
            end
         end
         @(posedge clk); #1;
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_sel   = g;
            m_last  = g;
            src_q[g].push_back(in_data[g*8 +: 8]);
         end else if (load) begin
            m_valid = 1'b0;
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 4'b0000;
      in_data   = '0;
      out_ready = 1'b0;
      pattern   = 32'hD3C2_B1A0;
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_idle_drain();
      test_random_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
